div_iter_param: RTL and testbench
=================================

Name: div_iter_param

Overview:
- Parametrised iterative restoring divider; the next generation of the current fixed 32-bit div unit.
- Instantiated beside ex. ex drives operands, start and sign mode, holds stallreq while busy, and captures the result into HI/LO.
- Adds generic operand width, explicit busy and divide-by-zero flags, and defined signed-overflow handling.
- Optional leading-zero early termination is compiled in by macro.

Parameters:
- DATA_W, 32, operand width in bits; any value >= 4.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned.
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  request; held high by ex until it has consumed the result.
- annul_i  input  1  abort the operation in progress (pipeline flush).
- result_o  output  2*DATA_W  {remainder, quotient}; upper half goes to HI, lower half to LO.
- ready_o  output  1  result_o valid.
- busy_o  output  1  high in every state except IDLE.
- div_zero_o  output  1  current result came from a zero divisor.

Behaviour:
- Reset: on rst=1 at a rising edge, state=IDLE and result_o, ready_o, busy_o, div_zero_o all go to 0. This applies mid-operation; no partial result ever appears.
- All outputs are registered.
- FSM states: IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1, annul_i=0, divisor=0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON.
  - Operands and signed_div_i are sampled at this edge. Later input changes are ignored until the block returns to IDLE.
- Sign handling (signed mode): negative operands are converted to magnitudes (two's complement) before iterating.
- ON:
  - One quotient bit per cycle, MSB first.
  - Partial remainder is DATA_W+1 bits: trial-subtract the divisor magnitude; if non-negative keep it and shift in 1, else shift in 0.
  - Counter runs from 0 to DATA_W-1, then -> END.
  - annul_i=1 or start_i=0 in any ON cycle -> IDLE next edge, ready_o stays 0.
- BYZERO: one cycle, then -> END with result_o=0 and div_zero_o=1.
- Post-correction (signed mode, applied when entering END):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Overflow case -2^(DATA_W-1) / -1 yields quotient 2^(DATA_W-1) as a bit pattern (wraps) and remainder 0. No trap.
- END:
  - ready_o=1 and result_o is held stable.
  - Stays in END while start_i=1.
  - start_i=0 -> IDLE next edge, clearing ready_o (result_o keeps its value).
  - annul_i in END is ignored.
- Latency: start sampled at edge E0. ready_o is high after edge E0+DATA_W+1 for a nonzero divisor, and after edge E0+2 for a zero divisor.
- Throughput: one operation at a time. A new start is accepted only after a return to IDLE, so the minimum gap is one cycle in IDLE.
- busy_o is high in BYZERO, ON and END.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - On entry to ON, the dividend magnitude is pre-shifted left by its leading-zero count lz.
  - The counter starts at lz, so only DATA_W-lz iterations run.
  - A zero dividend (lz=DATA_W) passes through ON for exactly one cycle with result 0.
  - Latency becomes E0+max(DATA_W-lz,1)+1. Results are identical to the fixed-latency build.
- Undefined: fixed DATA_W iterations; no leading-zero logic synthesised.

Test Plan:
- DATA_W=32 unsigned 100/7: ready_o rises exactly 33 cycles after the start edge (macro off) with result_o={32'd2,32'd14}, div_zero_o=0. Hold start 3 more cycles: result stays stable. Drop start: ready_o=0, busy_o=0 on the next edge.
- Signed -7/2 (0xFFFFFFF9/0x00000002): quotient 0xFFFFFFFD and remainder 0xFFFFFFFF. Signed 7/-2: quotient 0xFFFFFFFD and remainder 0x00000001.
- Divide by zero, 5/0: ready_o 2 cycles after start, result_o=0, div_zero_o=1. A following 9/3 run clears div_zero_o and returns {0,3}.
- Signed 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF/1: quotient 0xFFFFFFFF, remainder 0.
- Abort and reset:
  - annul_i pulsed 10 cycles into ON -> IDLE next edge, ready_o never asserts; an immediate new start of 20/6 returns {2,3}.
  - rst asserted mid-ON -> all outputs 0 on the next edge.
- With DIV_EARLY_OUT_EN defined, DATA_W=32, 100/7:
  - lz=25, so ready_o comes 8 cycles after start with result {2,14}.
  - 0/9 gives ready_o after 2 cycles with result 0.
  - With DATA_W=8, 200/3 gives {2,66}.

Source files
------------

// File: rtl/div_iter_param.sv
// rtl/div_iter_param.sv - iterative restoring divider, {remainder, quotient} out.
// DIV_EARLY_OUT_EN: skip the dividend's leading zeros before iterating.
module div_iter_param #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  div_zero_o
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     rem_q;
  logic [DATA_W-1:0]     dq_q;
  logic [DATA_W-1:0]     dsr_q;
  logic                  quo_neg_q, rem_neg_q, dz_q;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  div_zero_q, div_zero_d;

  logic                  dvd_neg, dsr_neg, accept, take;
  logic [DATA_W-1:0]     dvd_mag, dsr_mag, rem_sub, quo_fix, rem_fix;
  logic [DATA_W:0]       shifted;

  assign dvd_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign dsr_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign dvd_mag = dvd_neg ? -opdata1_i : opdata1_i;
  assign dsr_mag = dsr_neg ? -opdata2_i : opdata2_i;

  // dq_q shifts dividend bits out of the top and quotient bits in at the bottom
  assign shifted = {rem_q, dq_q[DATA_W-1]};
  assign take    = shifted >= {1'b0, dsr_q};
  assign rem_sub = shifted[DATA_W-1:0] - dsr_q;

  assign quo_fix = quo_neg_q ? -dq_q : dq_q;
  assign rem_fix = rem_neg_q ? -rem_q : rem_q;

`ifdef DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] lz;
  always_comb begin
    lz = CNT_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (dvd_mag[i]) lz = CNT_W'(DATA_W - 1 - i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i && !annul_i) state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
      S_BYZERO: state_d = S_END;
      S_ON: begin
        if (annul_i || !start_i)  state_d = S_IDLE;
        else if (cnt_q >= LAST_CNT) state_d = S_END;
      end
      S_END:    if (!start_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ready rises one cycle after entering END; that cycle applies sign correction
  always_comb begin
    ready_d    = (state_q == S_END) && (state_d == S_END);
    busy_d     = (state_d != S_IDLE);
    result_d   = result_q;
    div_zero_d = div_zero_q;
    if (ready_d && !ready_q) begin
      result_d   = {rem_fix, quo_fix};
      div_zero_d = dz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign accept = (state_q == S_IDLE) && (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dq_q      <= '0;
      dsr_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else if (accept) begin
      rem_q     <= '0;
      dsr_q     <= dsr_mag;
      quo_neg_q <= dvd_neg ^ dsr_neg;
      rem_neg_q <= dvd_neg;
      dz_q      <= (opdata2_i == '0);
`ifdef DIV_EARLY_OUT_EN
      cnt_q     <= lz;
      dq_q      <= (opdata2_i == '0) ? '0 : (dvd_mag << lz);
`else
      cnt_q     <= '0;
      dq_q      <= (opdata2_i == '0) ? '0 : dvd_mag;
`endif
    end else if (state_q == S_ON) begin
      cnt_q <= cnt_q + CNT_W'(1);
      rem_q <= take ? rem_sub : shifted[DATA_W-1:0];
      dq_q  <= {dq_q[DATA_W-2:0], take};
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_div_iter_param.sv
// tb/tb_div_iter_param.sv - scoreboard bench for div_iter_param at DATA_W=32.
module tb_div_iter_param;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o, busy_o, div_zero_o;

  div_iter_param #(.DATA_W(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] res;
    logic           dz;
    int             e0;
    int             lat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic; SV signed division truncates toward zero.
  function automatic logic [2*W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
    longint sa, sb;
    logic [W-1:0] q, r;
    if (b == 0) return '0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
`ifdef DIV_EARLY_OUT_EN
    logic [W-1:0] m;
    int lz, n;
`endif
    if (b == 0) return 2;
`ifdef DIV_EARLY_OUT_EN
    m  = (s && a[W-1]) ? -a : a;
    lz = 0;
    while (lz < W && m[W-1-lz] == 1'b0) lz++;
    n = W - lz;
    if (n < 1) n = 1;
    return n + 1;
`else
    return W + 1;
`endif
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_div_i = s; start_i = 1'b1;
    e.res = model_res(a, b, s);
    e.dz  = (b == 0);
    e.e0  = cyc + 1;
    e.lat = model_lat(a, b, s);
    exp_q.push_back(e);
  endtask

  task automatic finish_op(input int hold);
    int n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      total++; bad++;
      $display("FAIL ready_timeout: got ready_o=0 expected 1 within 100 cycles");
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
    repeat (hold) @(negedge clk);
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = $urandom_range(0, 1);
    start_i = 1'b0;
    @(negedge clk);
    chk("ready_after_drop", {63'd0, ready_o}, 64'd0);
    chk("busy_after_drop", {63'd0, busy_o}, 64'd0);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
    issue(a, b, s);
    finish_op(hold);
  endtask

  // Monitor: pops on each rising ready_o, then checks result stability while held.
  exp_t cur;
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (ready_o && !prev_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ready: got ready_o=1 expected no result pending");
      end else begin
        cur = exp_q.pop_front();
        chk("result", result_o, cur.res);
        chk("div_zero", {63'd0, div_zero_o}, {63'd0, cur.dz});
        chk("latency", 64'(cyc - cur.e0), 64'(cur.lat));
      end
    end else if (ready_o && prev_ready) begin
      chk("result_stable", result_o, cur.res);
      chk("busy_in_end", {63'd0, busy_o}, 64'd1);
    end
    prev_ready = ready_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {result_o[2*W-1:3], ready_o, busy_o, div_zero_o} , 64'd0);
    rst = 1'b0;

    run(32'd100, 32'd7, 1'b0, 3);
    run(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run(32'd7, 32'hFFFF_FFFE, 1'b1, 1);
    run(32'd5, 32'd0, 1'b0, 0);
    run(32'd9, 32'd3, 1'b0, 0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run(32'd0, 32'd9, 1'b0, 0);
    run(32'h8000_0000, 32'd0, 1'b1, 0);

    // Abort 10 cycles into ON, then restart immediately with 20/6.
    issue(32'hFFFF_0000, 32'd3, 1'b0);
    void'(exp_q.pop_back());
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_ready", {63'd0, ready_o}, 64'd0);
    chk("annul_busy", {63'd0, busy_o}, 64'd0);
    start_i = 1'b0;
    run(32'd20, 32'd6, 1'b0, 0);

    // Synchronous reset mid-ON clears every output on the next edge.
    issue(32'h1234_5678, 32'd11, 1'b0);
    void'(exp_q.pop_back());
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_result", result_o, 64'd0);
    chk("rst_mid_flags", {61'd0, ready_o, busy_o, div_zero_o}, 64'd0);
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      run(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
